// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment display driver.
// Start/busy/done handshake; the last result is held stable between conversions.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SCR_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned MAXV = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t             state_q;
    logic [SCR_W-1:0]   scratch_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_pend_q;

    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_shl;

    // All BCD nibbles are corrected in parallel before the single-bit shift.
    always_comb begin
        scratch_adj = scratch_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                scratch_adj[BIN_W + 4*i +: 4] = scratch_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        scratch_shl = {scratch_adj[SCR_W-2:0], 1'b0};
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd_out    <= '0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        scratch_q  <= {{BCD_W{1'b0}}, bin_in};
                        ovf_pend_q <= (64'(bin_in) > MAXV);
                        cnt_q      <= '0;
                        busy       <= 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    scratch_q <= scratch_shl;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Overflowed inputs still run the full sequence; only the result saturates.
                    bcd_out  <= ovf_pend_q ? {DIGITS{4'h9}} : scratch_q[SCR_W-1 -: BCD_W];
                    overflow <= ovf_pend_q;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected results are queued at start and
// compared with latency and busy-length checks whenever done pulses.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W  = 14;
    localparam int unsigned DIGITS = 4;

    logic               clock_100Mhz;
    logic               reset;
    logic               start;
    logic [BIN_W-1:0]   bin_in;
    logic               busy;
    logic               done;
    logic [15:0]        bcd_out;
    logic               overflow;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .start        (start),
        .bin_in       (bin_in),
        .busy         (busy),
        .done         (done),
        .bcd_out      (bcd_out),
        .overflow     (overflow)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [15:0] last_bcd = 16'h0000;

    initial clock_100Mhz = 1'b0;
    always #5 clock_100Mhz = ~clock_100Mhz;
    always @(posedge clock_100Mhz) cyc++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int v, input int acc);
        exp_t e;
        e.acc = acc;
        if (v > 9999) begin
            e.bcd = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Monitor: compare every done pulse against the scoreboard.
    always @(negedge clock_100Mhz) begin
        if (reset) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check_val("spurious_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_val("bcd_out", 32'(bcd_out), 32'(e.bcd));
                    check_val("overflow", 32'(overflow), 32'(e.ovf));
                    check_val("latency", 32'(cyc - e.acc), 32'(BIN_W + 1));
                    check_val("busy_len", 32'(busy_cnt), 32'(BIN_W + 1));
                    check_val("busy_low_at_done", 32'(busy), 32'd0);
                end
                busy_cnt = 0;
            end
        end else begin
            busy_cnt = 0;
        end
    end

    // Drive start for one cycle at a negedge; the next posedge accepts it.
    task automatic send(input int v);
        start  = 1'b1;
        bin_in = BIN_W'(v);
        sb_q.push_back(model(v, cyc + 1));
        last_bcd = model(v, 0).bcd;
        @(negedge clock_100Mhz);
        start  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clock_100Mhz);
        check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clock_100Mhz);
        check_val("hold", 32'(bcd_out), 32'(last_bcd));
    endtask

    task automatic convert(input int v);
        @(negedge clock_100Mhz);
        send(v);
        drain();
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) begin
            @(negedge clock_100Mhz);
            check_val("rst_bcd", 32'(bcd_out), 32'h0);
            check_val("rst_busy", 32'(busy), 32'd0);
            check_val("rst_done", 32'(done), 32'd0);
            check_val("rst_ovf", 32'(overflow), 32'd0);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock_100Mhz);
            check_val("idle_busy", 32'(busy), 32'd0);
            check_val("idle_bcd", 32'(bcd_out), 32'h0);
        end

        convert(1234);
        convert(0);
        convert(9999);
        convert(10);
        convert(12000);
        convert(42);

        // Second start while busy must be ignored.
        @(negedge clock_100Mhz);
        send(5678);
        repeat (4) @(negedge clock_100Mhz);
        start  = 1'b1;
        bin_in = BIN_W'(1111);
        @(negedge clock_100Mhz);
        start  = 1'b0;
        drain();

        // Start during the done cycle gives a back-to-back conversion.
        @(negedge clock_100Mhz);
        send(7);
        for (int i = 0; i < 40 && !done; i++) @(negedge clock_100Mhz);
        check_val("saw_done", 32'(done), 32'd1);
        send(321);
        drain();

        // Asynchronous reset mid-conversion discards the result.
        @(negedge clock_100Mhz);
        send(8765);
        repeat (6) @(negedge clock_100Mhz);
        #2;
        reset = 1'b0;
        sb_q.delete();
        #1;
        check_val("async_busy", 32'(busy), 32'd0);
        check_val("async_bcd", 32'(bcd_out), 32'h0);
        check_val("async_done", 32'(done), 32'd0);
        repeat (2) @(negedge clock_100Mhz);
        reset = 1'b1;
        last_bcd = 16'h0000;
        repeat (20) @(negedge clock_100Mhz);
        check_val("post_rst_bcd", 32'(bcd_out), 32'h0);
        convert(4321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) that sits directly upstream of the 4-digit seven-segment display driver. It converts a binary count into four packed BCD digits over several cycles, so the display stage can select digits with plain bit slices instead of `/` and `%` dividers. It uses a start/busy/done handshake and holds the last result stable for the display multiplexer.

## Interface
- `BIN_W`, default 14: width of the binary input. Must satisfy 1 ≤ BIN_W ≤ 16.
- `DIGITS`, default 4: number of BCD digits produced.
- `clock_100Mhz`  in  1  100 MHz system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  request a conversion; sampled only in IDLE.
- `bin_in`  in  BIN_W  binary value; captured on the edge that accepts `start`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; `bcd_out` is valid and updated in this cycle.
- `bcd_out`  out  4*DIGITS  packed BCD result. `[15:12]` is thousands and `[3:0]` is units for the default configuration. Held until the next `done`.
- `overflow`  out  1  the last converted value exceeded 10^DIGITS−1. Updated together with `bcd_out`.

## Operation
- Local constant `MAXV` = 10^DIGITS − 1 (9999 for the default configuration).
- Scratch register is 4*DIGITS + BIN_W bits: BCD field in the upper bits, binary field in the lower bits. Shift counter is ⌈log2(BIN_W+1)⌉ bits.
- FSM states:
  - IDLE: `busy`=0. If `start`=1 at an edge:
    - load binary field ← `bin_in` and clear the BCD field;
    - latch `ovf_pend` ← (`bin_in` > MAXV);
    - clear the shift counter;
    - go to SHIFT.
  - SHIFT: on each edge:
    - every BCD nibble ≥ 5 gets +3 (all nibbles corrected in parallel);
    - then the whole scratch register shifts left by 1;
    - the counter increments.
    - After the BIN_W-th shift, go to DONE.
  - DONE: on the next edge:
    - `bcd_out` ← BCD field, or all nibbles 4'h9 if `ovf_pend`;
    - `overflow` ← `ovf_pend`;
    - `done` ← 1;
    - go to IDLE.
- `done` is registered and high for exactly one cycle.
- `start` outside IDLE is ignored, with no queueing. Changes to `bin_in` after capture have no effect.
- `start` high during the `done` cycle is accepted (the FSM is in IDLE), giving back-to-back conversions.
- An overflowed input still runs the full sequence; only the written result saturates.
- Reset (`reset`=0, any time, asynchronous):
  - state ← IDLE; scratch, counter and `ovf_pend` cleared;
  - `busy`=0, `done`=0, `bcd_out`=0 (display shows "0000"), `overflow`=0.
  - An in-flight conversion is discarded and no `done` is produced.
  - Normal operation resumes on the first rising edge after `reset` returns to 1.

## Timing
- Let E0 be the edge that accepts `start`.
- `busy` is high from after E0 until the edge E(BIN_W+1), inclusive.
- Shifts occur on edges E1…E(BIN_W).
- At E(BIN_W+1): `bcd_out`/`overflow` update, `done` rises and `busy` falls.
- Latency from the accepting edge to `done` is BIN_W+1 cycles (15 for the default configuration).
- Maximum throughput is one conversion per BIN_W+2 cycles with `start` held high.
- Outputs are purely registered. The downstream display stage can sample `bcd_out` in any cycle and never sees a partial result.
- Critical path is one add-3 compare/add per nibble plus the shift mux. This is comfortably within 10 ns.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release with `start`=0 → `bcd_out`=16'h0000, `busy`=0, `done`=0 and `overflow`=0 throughout.
- Basic conversion: `bin_in`=1234 with a 1-cycle `start` → `busy` high for 15 cycles, `done` a single pulse 15 cycles after the accepting edge, `bcd_out`=16'h1234, `overflow`=0.
- Boundaries:
  - `bin_in`=0 → 16'h0000;
  - `bin_in`=9999 → 16'h9999, `overflow`=0;
  - `bin_in`=10 → 16'h0010.
- Overflow: `bin_in`=12000 → `bcd_out`=16'h9999, `overflow`=1. A following conversion of 42 → 16'h0042 with `overflow`=0.
- Handshake:
  - Convert 5678, then pulse `start` again at cycle 5 with `bin_in`=1111 → second `start` ignored, result is 16'h5678.
  - `start`=1 with `bin_in`=321 during the `done` cycle → accepted; next `done` 15 cycles later with 16'h0321.
- Mid-conversion reset: assert `reset`=0 on cycle 7 of converting 8765 → `busy`=0 and `bcd_out`=0 immediately (asynchronous); no `done` follows; a fresh conversion after release works normally.
